// File: rtl/cache_ctrl_nway_fsm.sv
// cache_ctrl_nway_fsm: N-way set-associative cache control FSM with per-set valid/dirty/true-LRU state,
// victim selection, dirty writeback and req/ack memory handshake.
module cache_ctrl_nway_fsm #(
   parameter int WAYS  = 4,
   parameter int WAY_W = 2,
   parameter int SETS  = 16,
   parameter int SET_W = 4
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             req_valid,
   input  logic             req_write,
   input  logic [SET_W-1:0] req_set,
   input  logic             hit,
   input  logic [WAY_W-1:0] hit_way,
   input  logic             inv_all,
   input  logic             mem_ack,
   output logic             req_ready,
   output logic             miss,
   output logic             resp_valid,
   output logic             write_enable,
   output logic [WAY_W-1:0] update_way,
   output logic             mem_req,
   output logic             mem_we,
   output logic [SET_W-1:0] mem_set,
   output logic [2:0]       state
);
   typedef enum logic [2:0] {IDLE = 3'd0, HIT = 3'd1, WRITEBACK = 3'd2, REFILL = 3'd3, INSTALL = 3'd4} state_t;
   state_t state_q, state_d;
   logic [SETS-1:0][WAYS-1:0] valid_q, valid_d, dirty_q, dirty_d;
   logic [SETS-1:0][WAYS-1:0][WAY_W-1:0] age_q, age_d;
   logic wr_q, wr_d;
   logic [SET_W-1:0] set_q, set_d;
   logic [WAY_W-1:0] way_q, way_d;
   logic [WAY_W-1:0] victim;
   logic victim_dirty, touch;
   // Lowest-index invalid way wins; otherwise the oldest way.
   always_comb begin
      victim = '0;
      for (int i = 0; i < WAYS; i++)
         if (age_q[req_set][i] == WAY_W'(WAYS - 1)) victim = WAY_W'(i);
      for (int i = WAYS - 1; i >= 0; i--)
         if (!valid_q[req_set][i]) victim = WAY_W'(i);
      victim_dirty = valid_q[req_set][victim] & dirty_q[req_set][victim];
   end
   always_comb begin
      state_d = state_q;
      valid_d = valid_q;
      dirty_d = dirty_q;
      age_d   = age_q;
      wr_d    = wr_q;
      set_d   = set_q;
      way_d   = way_q;
      touch   = 1'b0;
      case (state_q)
         IDLE: begin
            if (inv_all) begin
               valid_d = '0;
               dirty_d = '0;
               for (int s = 0; s < SETS; s++)
                  for (int i = 0; i < WAYS; i++) age_d[s][i] = WAY_W'(i);
            end else if (req_valid) begin
               wr_d    = req_write;
               set_d   = req_set;
               way_d   = hit ? hit_way : victim;
               state_d = hit ? HIT : (victim_dirty ? WRITEBACK : REFILL);
            end
         end
         HIT: begin
            touch = 1'b1;
            if (wr_q) dirty_d[set_q][way_q] = 1'b1;
            state_d = IDLE;
         end
         WRITEBACK: if (mem_ack) begin
            dirty_d[set_q][way_q] = 1'b0;
            state_d = REFILL;
         end
         REFILL: if (mem_ack) state_d = INSTALL;
         INSTALL: begin
            touch = 1'b1;
            valid_d[set_q][way_q] = 1'b1;
            dirty_d[set_q][way_q] = wr_q;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // Move-to-front: ways younger than the touched one age by one.
      if (touch) begin
         for (int i = 0; i < WAYS; i++)
            if (age_q[set_q][i] < age_q[set_q][way_q]) age_d[set_q][i] = age_q[set_q][i] + WAY_W'(1);
         age_d[set_q][way_q] = '0;
      end
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         valid_q <= '0;
         dirty_q <= '0;
         for (int s = 0; s < SETS; s++)
            for (int i = 0; i < WAYS; i++) age_q[s][i] <= WAY_W'(i);
         wr_q    <= 1'b0;
         set_q   <= '0;
         way_q   <= '0;
      end else begin
         state_q <= state_d;
         valid_q <= valid_d;
         dirty_q <= dirty_d;
         age_q   <= age_d;
         wr_q    <= wr_d;
         set_q   <= set_d;
         way_q   <= way_d;
      end
   end
   assign req_ready    = state_q == IDLE;
   assign miss         = req_ready & req_valid & ~hit & ~inv_all;
   assign resp_valid   = state_q == HIT || state_q == INSTALL;
   assign write_enable = (state_q == HIT && wr_q) || state_q == INSTALL;
   assign update_way   = state_q == IDLE ? '0 : way_q;
   assign mem_req      = state_q == WRITEBACK || state_q == REFILL;
   assign mem_we       = state_q == WRITEBACK;
   assign mem_set      = mem_req ? set_q : '0;
   assign state        = state_q;
endmodule

// File: tb/tb_cache_ctrl_nway_fsm.sv
// tb_cache_ctrl_nway_fsm: directed transactions checked every cycle against a recency-list cache model,
// plus hand-computed victim/latency expectations.
module tb_cache_ctrl_nway_fsm;
   logic clk = 0;
   logic reset_n = 0;
   logic req_valid = 0, req_write = 0, hit = 0, inv_all = 0, mem_ack = 0;
   logic [3:0] req_set = 0;
   logic [1:0] hit_way = 0;
   logic req_ready, miss, resp_valid, write_enable, mem_req, mem_we;
   logic [1:0] update_way;
   logic [3:0] mem_set;
   logic [2:0] state;
   int checks = 0, errors = 0;
   int ack_dly = 0;

   cache_ctrl_nway_fsm dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_write(req_write), .req_set(req_set),
      .hit(hit), .hit_way(hit_way), .inv_all(inv_all), .mem_ack(mem_ack), .req_ready(req_ready),
      .miss(miss), .resp_valid(resp_valid), .write_enable(write_enable), .update_way(update_way),
      .mem_req(mem_req), .mem_we(mem_we), .mem_set(mem_set), .state(state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model: phase 0 idle, 1 hit response, 2 writeback, 3 refill, 4 install.
   int p = 0, m_wr = 0, m_set = 0, m_way = 0;
   bit mv[16][4], md[16][4];
   int lst[16][4];

   function automatic void mreset();
      p = 0;
      for (int s = 0; s < 16; s++)
         for (int k = 0; k < 4; k++) begin
            mv[s][k] = 0; md[s][k] = 0; lst[s][k] = k;
         end
   endfunction

   function automatic void mtouch(input int s, input int w);
      int pos = 0;
      for (int k = 0; k < 4; k++) if (lst[s][k] == w) pos = k;
      for (int k = pos; k > 0; k--) lst[s][k] = lst[s][k-1];
      lst[s][0] = w;
   endfunction

   function automatic int mvictim(input int s);
      for (int k = 0; k < 4; k++) if (!mv[s][k]) return k;
      return lst[s][3];
   endfunction

   initial mreset();

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) mreset();
      else if (p == 0) begin
         if (inv_all) begin
            for (int s = 0; s < 16; s++)
               for (int k = 0; k < 4; k++) begin
                  mv[s][k] = 0; md[s][k] = 0; lst[s][k] = k;
               end
         end else if (req_valid) begin
            m_wr = int'(req_write); m_set = int'(req_set);
            if (hit) begin m_way = int'(hit_way); p = 1; end
            else begin
               m_way = mvictim(m_set);
               p = (mv[m_set][m_way] && md[m_set][m_way]) ? 2 : 3;
            end
         end
      end else if (p == 1) begin
         mtouch(m_set, m_way);
         if (m_wr != 0) md[m_set][m_way] = 1;
         p = 0;
      end else if (p == 2) begin
         if (mem_ack) begin md[m_set][m_way] = 0; p = 3; end
      end else if (p == 3) begin
         if (mem_ack) p = 4;
      end else begin
         mv[m_set][m_way] = 1; md[m_set][m_way] = (m_wr != 0);
         mtouch(m_set, m_way);
         p = 0;
      end
   end

   always @(negedge clk) begin
      chk("req_ready", req_ready, p == 0);
      chk("miss", miss, p == 0 && req_valid && !hit && !inv_all);
      chk("resp_valid", resp_valid, p == 1 || p == 4);
      chk("write_enable", write_enable, (p == 1 && m_wr != 0) || p == 4);
      chk("update_way", update_way, p == 0 ? 0 : m_way);
      chk("mem_req", mem_req, p == 2 || p == 3);
      chk("mem_we", mem_we, p == 2);
      chk("mem_set", mem_set, (p == 2 || p == 3) ? m_set : 0);
      chk("state", state, p);
   end

   // Memory responder: ack after ack_dly waiting cycles of each transfer phase.
   initial begin
      int cnt = 0;
      forever begin
         @(posedge clk); #2;
         if (mem_req) begin
            if (cnt >= ack_dly) begin mem_ack = 1; cnt = 0; end
            else begin mem_ack = 0; cnt++; end
         end else begin
            mem_ack = 0; cnt = 0;
         end
      end
   end

   task automatic txn(input bit w, input int s, input bit h, input int hw, input int dly,
                      output int cyc, output int way, output bit wb, output int wbset);
      bit done = 0;
      ack_dly = dly;
      req_valid = 1; req_write = w; req_set = 4'(s); hit = h; hit_way = 2'(hw);
      @(posedge clk); #2;
      req_valid = 0; hit = 0;
      cyc = 1; way = -1; wb = 0; wbset = 0;
      repeat (60) begin
         @(negedge clk);
         if (mem_req && mem_we) begin wb = 1; wbset = int'(mem_set); end
         if (resp_valid) begin way = int'(update_way); done = 1; break; end
         @(posedge clk); #2;
         cyc++;
      end
      chk("resp_seen", done, 1);
      @(posedge clk); #2;
   endtask

   initial begin
      int cyc, way, wbset;
      bit wb;
      #500000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

   initial begin
      int cyc, way, wbset;
      bit wb;
      repeat (3) @(posedge clk);
      #2;
      chk("reset_ready", req_ready, 1);
      chk("reset_state", state, 0);
      reset_n = 1;
      @(posedge clk); #2;
      // 1: clean read miss, ack after 2 waiting cycles
      txn(0, 3, 0, 0, 2, cyc, way, wb, wbset);
      chk("t1_way", way, 0);
      chk("t1_lat", cyc, 4);
      chk("t1_wb", wb, 0);
      chk("t1_model_valid", mv[3][0], 1);
      chk("t1_model_dirty", md[3][0], 0);
      // 2: fill set 5, hit way0, next miss evicts way1
      for (int k = 0; k < 4; k++) begin
         txn(0, 5, 0, 0, 1, cyc, way, wb, wbset);
         chk("t2_fill_way", way, k);
         chk("t2_fill_lat", cyc, 3);
      end
      txn(0, 5, 1, 0, 1, cyc, way, wb, wbset);
      chk("t2_hit_lat", cyc, 1);
      txn(0, 5, 0, 0, 1, cyc, way, wb, wbset);
      chk("t2_victim", way, 1);
      chk("t2_wb", wb, 0);
      // 3: dirty way2 of set 7 made LRU, then write miss
      for (int k = 0; k < 4; k++) txn(0, 7, 0, 0, 1, cyc, way, wb, wbset);
      txn(1, 7, 1, 2, 1, cyc, way, wb, wbset);
      chk("t3_whit_way", way, 2);
      txn(0, 7, 1, 0, 1, cyc, way, wb, wbset);
      txn(0, 7, 1, 1, 1, cyc, way, wb, wbset);
      txn(0, 7, 1, 3, 1, cyc, way, wb, wbset);
      txn(1, 7, 0, 0, 1, cyc, way, wb, wbset);
      chk("t3_victim", way, 2);
      chk("t3_wb", wb, 1);
      chk("t3_wbset", wbset, 7);
      chk("t3_lat", cyc, 5);
      chk("t3_model_dirty", md[7][2], 1);
      // 4: inv_all beats a pending request
      inv_all = 1; req_valid = 1; req_set = 5; hit = 0;
      @(negedge clk);
      chk("t4_no_miss", miss, 0);
      @(posedge clk); #2;
      inv_all = 0; req_valid = 0;
      chk("t4_state", state, 0);
      txn(0, 5, 0, 0, 0, cyc, way, wb, wbset);
      chk("t4_victim", way, 0);
      chk("t4_lat", cyc, 2);
      // 6: zero-wait ack on a dirty miss
      for (int k = 0; k < 4; k++) txn(1, 9, 0, 0, 0, cyc, way, wb, wbset);
      txn(0, 9, 0, 0, 0, cyc, way, wb, wbset);
      chk("t6_victim", way, 0);
      chk("t6_wb", wb, 1);
      chk("t6_lat", cyc, 3);
      // 5: async reset mid-refill
      ack_dly = 20;
      req_valid = 1; req_write = 0; req_set = 2; hit = 0;
      @(posedge clk); #2;
      req_valid = 0;
      @(posedge clk); #2;
      chk("t5_in_refill", mem_req, 1);
      reset_n = 0;
      #1;
      chk("t5_mem_req", mem_req, 0);
      chk("t5_state", state, 0);
      chk("t5_resp", resp_valid, 0);
      repeat (2) @(posedge clk);
      #2;
      reset_n = 1;
      @(posedge clk); #2;
      for (int k = 0; k < 4; k++) txn(0, 5, 0, 0, 0, cyc, way, wb, wbset);
      txn(0, 5, 0, 0, 0, cyc, way, wb, wbset);
      chk("t5_age_victim", way, 0);
      chk("t5_wb", wb, 0);
      repeat (2) @(posedge clk);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
